// File: rtl/alu_pkg.sv
// Shared ALU op codes, BIST FSM encoding and the ALU golden function.
// Used by both the ALU datapath and its self-test engine.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic [31:0] alu_golden(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op
  );
    logic [31:0] r;
    r = 32'h0;
    unique case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_SRL: r = a >> b[4:0];
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// Operand generator: 32-bit Galois LFSR, x^32+x^22+x^2+x+1.
// Offers the next two draws at once; a step consumes both.
module alu_bist_lfsr #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] draw_a,
  output logic [31:0] draw_b
);

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic [31:0] q;

  function automatic logic [31:0] advance(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
  endfunction

  assign draw_a = advance(q);
  assign draw_b = advance(draw_a);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else if (step) q <= draw_b;
  end

endmodule

// File: rtl/alu_bist.sv
// Self-test engine for the 32-bit ALU: drive, settle, check, count.
// Define ALU_BIST_LOG_EN to add first-mismatch capture ports.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          N_VECTORS     = 16,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED     = 32'h1ACE_B00C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] vec_index,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
`ifdef ALU_BIST_LOG_EN
  ,
  output logic        fail_valid,
  output logic [15:0] fail_index,
  output logic [2:0]  fail_op,
  output logic [31:0] fail_expected,
  output logic [31:0] fail_actual
`endif
);

  localparam logic [15:0] LAST_IDX = 16'(N_VECTORS - 1);
  localparam logic [3:0] SETTLE_LOAD =
    4'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  localparam logic [31:0] SEED =
    (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [2:0]  state;
  logic [3:0]  settle_cnt;
  logic        lfsr_step;
  logic [31:0] draw_a;
  logic [31:0] draw_b;
  logic [31:0] exp_result;
  logic        mismatch;

  // vector 0 is the fixed all-zero pair and consumes no draws
  assign lfsr_step = (state == ST_DRIVE) && (vec_index != 16'd0);
  assign exp_result = alu_golden(alu_A, alu_B, alu_operation);
  assign mismatch = (alu_result != exp_result) ||
                    (alu_zero != (exp_result == 32'h0));

  alu_bist_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .draw_a(draw_a),
    .draw_b(draw_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      settle_cnt    <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b1;
      err_count     <= 16'd0;
      vec_index     <= 16'd0;
      alu_A         <= 32'h0;
      alu_B         <= 32'h0;
      alu_operation <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            pass      <= 1'b1;
            err_count <= 16'd0;
            vec_index <= 16'd0;
          end
        end
        ST_DRIVE: begin
          alu_operation <= vec_index[2:0];
          alu_A <= (vec_index == 16'd0) ? 32'h0 : draw_a;
          alu_B <= (vec_index == 16'd0) ? 32'h0 : draw_b;
          settle_cnt <= SETTLE_LOAD;
          state <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 4'd0) state <= ST_CHECK;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            pass <= 1'b0;
            if (err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
          end
          if (vec_index == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            vec_index <= vec_index + 16'd1;
            state     <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_BIST_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE && start)) begin
      fail_valid    <= 1'b0;
      fail_index    <= 16'd0;
      fail_op       <= 3'd0;
      fail_expected <= 32'h0;
      fail_actual   <= 32'h0;
    end else if (state == ST_CHECK && mismatch && !fail_valid) begin
      fail_valid    <= 1'b1;
      fail_index    <= vec_index;
      fail_op       <= alu_operation;
      fail_expected <= exp_result;
      fail_actual   <= alu_result;
    end
  end
`endif

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: faultable ALU model, schedule-based reference
// model checked every cycle, plus directed literal checks.
module tb_alu_bist;

  localparam int N = 16;
  localparam int S = 1;
  localparam int P = S + 2;
  localparam int END_T = N * P + 1;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count, vec_index;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_operation;
  logic        alu_zero;
`ifdef ALU_BIST_LOG_EN
  logic        fail_valid;
  logic [15:0] fail_index;
  logic [2:0]  fail_op;
  logic [31:0] fail_expected, fail_actual;
`endif

  int fault = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_bist #(
    .N_VECTORS(N),
    .SETTLE_CYCLES(S),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_index(vec_index),
    .alu_A(alu_A), .alu_B(alu_B),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_BIST_LOG_EN
    ,
    .fail_valid(fail_valid), .fail_index(fail_index),
    .fail_op(fail_op), .fail_expected(fail_expected),
    .fail_actual(fail_actual)
`endif
  );

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return a >> b[4:0];
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // ALU under test: 0 good, 1 ADD bit0 flipped, 2 Zero stuck 0, 3 inverted
  logic [31:0] gold;
  always_comb begin
    gold = ref_alu(alu_A, alu_B, alu_operation);
    alu_result = gold;
    alu_zero = (gold == 32'h0);
    case (fault)
      1: if (alu_operation == 3'd2) alu_result = gold ^ 32'h1;
      2: alu_zero = 1'b0;
      3: alu_result = ~gold;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: run timeline derived from start edge
  bit          mvalid = 0, mrun = 0, mdone = 0, have_run = 0;
  int          mt = 0;
  logic [31:0] lfsr = SEED;
  logic [31:0] va[N], vb[N];
  bit          mis[N];
  logic [31:0] hold_a = 0, hold_b = 0;
  logic [2:0]  hold_op = 0;

  always @(posedge clk) begin
    mdone = 0;
    if (rst) begin
      mvalid = 1; mrun = 0; mt = 0; have_run = 0;
      lfsr = SEED; hold_a = 0; hold_b = 0; hold_op = 0;
    end else if (mrun) begin
      mt++;
      if (mt == END_T) begin mrun = 0; mdone = 1; end
    end else if (start) begin
      if (have_run) begin
        hold_a = va[N-1]; hold_b = vb[N-1]; hold_op = 3'(N - 1);
      end
      for (int k = 0; k < N; k++) begin
        logic [31:0] r;
        if (k == 0) begin
          va[k] = 0; vb[k] = 0;
        end else begin
          lfsr = lfsr_next(lfsr); va[k] = lfsr;
          lfsr = lfsr_next(lfsr); vb[k] = lfsr;
        end
        r = ref_alu(va[k], vb[k], 3'(k));
        mis[k] = (fault == 3) || (fault == 1 && k % 8 == 2) ||
                 (fault == 2 && r == 0);
      end
      have_run = 1; mrun = 1; mt = 0;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [31:0] ea, eb;
      int ev, nchk, eerr, efirst, k;
      ea = 0; eb = 0; ev = 0; eerr = 0; efirst = -1; k = 0;
      if (have_run) begin
        ev = (mt / P > N - 1) ? N - 1 : mt / P;
        nchk = (mt / P > N) ? N : mt / P;
        for (int i = 0; i < nchk; i++)
          if (mis[i]) begin
            eerr++;
            if (efirst < 0) efirst = i;
          end
        if (mt == 0) begin
          ea = hold_a; eb = hold_b; k = int'(hold_op);
        end else begin
          k = ((mt - 1) / P > N - 1) ? N - 1 : (mt - 1) / P;
          ea = va[k]; eb = vb[k];
        end
      end
      chk("busy", 32'(busy), 32'(mrun));
      chk("done", 32'(done), 32'(mdone));
      chk("pass", 32'(pass), 32'(eerr == 0));
      chk("err_count", 32'(err_count), 32'(eerr));
      chk("vec_index", 32'(vec_index), 32'(ev));
      chk("alu_A", alu_A, ea);
      chk("alu_B", alu_B, eb);
      chk("alu_op", 32'(alu_operation), 32'(k % 8));
`ifdef ALU_BIST_LOG_EN
      chk("fail_valid", 32'(fail_valid), 32'(efirst >= 0));
      if (efirst >= 0) begin
        chk("fail_index", 32'(fail_index), 32'(efirst));
        chk("fail_op", 32'(fail_op), 32'(efirst % 8));
        chk("fail_expected", fail_expected,
            ref_alu(va[efirst], vb[efirst], 3'(efirst)));
      end
`endif
    end
  end

  task automatic start_run();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
  endtask

  initial begin
    int lat, nd, guard;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pass", 32'(pass), 32'd1);
    chk("reset_err", 32'(err_count), 32'd0);

    // good ALU: literal vector-1 operands and latency
    fault = 0;
    start_run();
    repeat (5) @(posedge clk);
    #1;
    chk("vec1_A", alu_A, 32'h0D67_5806);
    chk("vec1_B", alu_B, 32'h06B3_AC03);
    chk("vec1_op", 32'(alu_operation), 32'd1);
    wait_done(5, lat);
    chk("latency_good", 32'(lat), 32'd49);
    chk("pass_good", 32'(pass), 32'd1);
    chk("err_good", 32'(err_count), 32'd0);

    // ADD bit0 flipped: vectors 2 and 10 fail
    fault = 1;
    start_run();
    wait_done(0, lat);
    chk("err_add", 32'(err_count), 32'd2);
    chk("pass_add", 32'(pass), 32'd0);
`ifdef ALU_BIST_LOG_EN
    chk("log_index_add", 32'(fail_index), 32'd2);
    chk("log_op_add", 32'(fail_op), 32'd2);
`endif

    // Zero stuck low: the all-zero vector 0 must fail
    fault = 2;
    start_run();
    wait_done(0, lat);
    chk("pass_zero", 32'(pass), 32'd0);

    // always-wrong ALU, reset mid-run at vector 5
    fault = 3;
    start_run();
    guard = 0;
    while (vec_index != 16'd5 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("reach_vec5", 32'(vec_index), 32'd5);
    #1 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err_count), 32'd0);
    count_done(60, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    fault = 0;
    start_run();
    wait_done(0, lat);
    chk("latency_after_rst", 32'(lat), 32'd49);

    // start held for 10 cycles mid-run: one run only
    start_run();
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    repeat (10) @(posedge clk);
    #2 start = 1'b0;
    count_done(60, nd);
    chk("held_start_done", 32'(nd), 32'd1);

    // start sampled while in DONE is dropped
    start_run();
    repeat (48) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("done_edge_pulse", 32'(done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_start_ignored", 32'(busy), 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
